// File: rtl/asteroid_spawner.sv
// Asteroid pool scheduler: spawn/retire slots, fold hit/miss into score/health, IDLE/PLAY/GAMEOVER.
// Optional ASTEROID_RANDOM_X_EN selects an LFSR column generator instead of the stepped index.
module asteroid_spawner #(
  parameter int unsigned SLOTS          = 4,
  parameter int unsigned SPAWN_INTERVAL = 120,
  parameter int unsigned X_MIN          = 40,
  parameter int unsigned START_HEALTH   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  start,
  input  logic [SLOTS-1:0]      slot_hit,
  input  logic [SLOTS-1:0]      slot_miss,
  output logic [SLOTS-1:0]      slot_enable_n,
  output logic [10*SLOTS-1:0]   slot_middle,
  output logic [3:0]            score_add,
  output logic [2:0]            health,
  output logic                  playing,
  output logic                  game_over
);

  localparam int unsigned CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_start_d;
  logic [SLOTS-1:0]    r_en_n, w_en_n_nxt;
  logic [10*SLOTS-1:0] r_mid, w_mid_nxt;
  logic [3:0]          r_score, w_score_nxt;
  logic [2:0]          r_health, w_health_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_pend, w_pend_nxt;
  logic                r_playing, w_playing_nxt;
  logic                r_over, w_over_nxt;

`ifdef ASTEROID_RANDOM_X_EN
  logic [9:0]          r_lfsr, w_lfsr_nxt;
`else
  logic [2:0]          r_k, w_k_nxt;
`endif

  logic                w_start_rise;
  logic [SLOTS-1:0]    w_active, w_vhit, w_vmiss, w_retire, w_free_after, w_grant_oh;
  logic [3:0]          w_hit_cnt, w_miss_cnt;
  logic [2:0]          w_health_sub;
  logic                w_spawn_tick, w_req, w_grant;
  logic [9:0]          w_col;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_start_d <= 1'b0;
      r_en_n    <= '1;
      r_mid     <= {SLOTS{10'(X_MIN)}};
      r_score   <= '0;
      r_health  <= 3'(START_HEALTH);
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_playing <= 1'b0;
      r_over    <= 1'b0;
`ifdef ASTEROID_RANDOM_X_EN
      r_lfsr    <= 10'h2A5;
`else
      r_k       <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= start;
      r_en_n    <= w_en_n_nxt;
      r_mid     <= w_mid_nxt;
      r_score   <= w_score_nxt;
      r_health  <= w_health_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend    <= w_pend_nxt;
      r_playing <= w_playing_nxt;
      r_over    <= w_over_nxt;
`ifdef ASTEROID_RANDOM_X_EN
      r_lfsr    <= w_lfsr_nxt;
`else
      r_k       <= w_k_nxt;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt   = r_state;
    w_en_n_nxt    = r_en_n;
    w_mid_nxt     = r_mid;
    w_score_nxt   = '0;
    w_health_nxt  = r_health;
    w_cnt_nxt     = r_cnt;
    w_pend_nxt    = r_pend;
    w_playing_nxt = r_playing;
    w_over_nxt    = r_over;
    w_grant       = 1'b0;
    w_req         = 1'b0;
    w_hit_cnt     = '0;
    w_miss_cnt    = '0;
    w_grant_oh    = '0;

    w_start_rise = start & ~r_start_d;
    w_active     = ~r_en_n;
    w_vhit       = slot_hit & w_active;
    w_vmiss      = slot_miss & w_active & ~slot_hit;
    w_retire     = (slot_hit | slot_miss) & w_active;
    w_free_after = r_en_n | w_retire;
    w_spawn_tick = frame_tick && (r_cnt == CNT_W'(SPAWN_INTERVAL - 1));

    for (int i = 0; i < int'(SLOTS); i++) begin
      w_hit_cnt  = w_hit_cnt + 4'(w_vhit[i]);
      w_miss_cnt = w_miss_cnt + 4'(w_vmiss[i]);
    end

    // Lowest-index free slot wins; scanning downward leaves the lowest in place
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (w_free_after[i]) begin
        w_grant_oh    = '0;
        w_grant_oh[i] = 1'b1;
      end
    end

    if ({1'b0, r_health} <= w_miss_cnt) w_health_sub = '0;
    else                                w_health_sub = r_health - w_miss_cnt[2:0];

`ifdef ASTEROID_RANDOM_X_EN
    w_col = 10'(X_MIN) + {1'b0, r_lfsr[8:0]};
`else
    w_col = 10'(X_MIN) + {1'b0, r_k, 6'd0};
`endif

    case (r_state)
      S_IDLE: begin
        w_en_n_nxt = '1;
        if (w_start_rise) begin
          w_state_nxt   = S_PLAY;
          w_health_nxt  = 3'(START_HEALTH);
          w_cnt_nxt     = '0;
          w_pend_nxt    = 1'b0;
          w_playing_nxt = 1'b1;
          w_over_nxt    = 1'b0;
        end
      end
      S_PLAY: begin
        w_score_nxt  = w_hit_cnt;
        w_health_nxt = w_health_sub;
        if (w_health_sub == 3'd0) begin
          w_state_nxt   = S_OVER;
          w_en_n_nxt    = '1;
          w_pend_nxt    = 1'b0;
          w_playing_nxt = 1'b0;
          w_over_nxt    = 1'b1;
        end else begin
          w_en_n_nxt = w_free_after;
          if (frame_tick) w_cnt_nxt = w_spawn_tick ? '0 : r_cnt + 1'b1;
          // A single request is held until a slot frees; extra intervals do not stack
          w_req = r_pend | w_spawn_tick;
          if (w_req && (|w_free_after)) begin
            w_grant    = 1'b1;
            w_en_n_nxt = w_free_after & ~w_grant_oh;
            w_pend_nxt = 1'b0;
            for (int i = 0; i < int'(SLOTS); i++) begin
              if (w_grant_oh[i]) w_mid_nxt[10*i +: 10] = w_col;
            end
          end else begin
            w_pend_nxt = w_req;
          end
        end
      end
      S_OVER: begin
        w_en_n_nxt   = '1;
        w_health_nxt = '0;
        if (w_start_rise) begin
          w_state_nxt   = S_IDLE;
          w_playing_nxt = 1'b0;
          w_over_nxt    = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

`ifdef ASTEROID_RANDOM_X_EN
    w_lfsr_nxt = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
`else
    w_k_nxt = w_grant ? r_k + 3'd1 : r_k;
`endif
  end

  assign slot_enable_n = r_en_n;
  assign slot_middle   = r_mid;
  assign score_add     = r_score;
  assign health        = r_health;
  assign playing       = r_playing;
  assign game_over     = r_over;

endmodule
